mips_cpu_muldiv: RTL and testbench

//  Parametrised multi-cycle multiply/divide unit that owns the HI/LO architectural registers.

---
 rtl/mips_cpu_muldiv_pkg.sv | 27 ++
 rtl/mips_cpu_muldiv_divstep.sv | 25 ++
 rtl/mips_cpu_muldiv.sv | 153 +++++++++++++++
 tb/tb_mips_cpu_muldiv.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_muldiv_pkg.sv
// mips_cpu_muldiv_pkg: funct codes, FSM state type and negation helper for the HI/LO muldiv unit.
`default_nettype none
package mips_cpu_muldiv_pkg;

  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Widest value twos_neg can handle; callers zero-extend and keep the low bits.
  localparam int MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DIV   = 2'd2,
    FIXUP = 2'd3
  } state_t;

  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv_divstep.sv
// mips_cpu_muldiv_divstep: one combinational restoring-division step (shift in a bit, trial subtract).
`default_nettype none
module mips_cpu_muldiv_divstep
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividend_bit,
  output logic [WIDTH-1:0] rem_next,
  output logic             quo_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  assign shifted  = {rem, dividend_bit};
  assign quo_bit  = (shifted >= {1'b0, divisor});
  // Whenever the subtraction is taken the result is below the divisor, so the low bits suffice.
  assign diff     = shifted[WIDTH-1:0] - divisor;
  assign rem_next = quo_bit ? diff : shifted[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO (start/busy/done).
// Define MIPS_CPU_MULDIV_FASTMUL_EN for a registered single-cycle multiply (WIDTH must be <= 127).
`default_nettype none
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid_out,
  output logic [WIDTH-1:0] hi_reg,
  output logic [WIDTH-1:0] lo_reg
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod;     // MUL: {partial product, multiplier}; DIV: low half = dividend/quotient
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   opr;      // multiplicand or divisor magnitude
  logic               neg_res;
  logic               rem_neg;
  logic               div0;
  logic               is_div;

  logic               signed_op;
  logic [MAX_W-1:0]   neg_a, neg_b, neg_prod, neg_quo, neg_rmd;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   step_rem;
  logic               step_q;
  logic               unused_neg;

  assign signed_op = ~opcode[0];
  assign neg_a     = twos_neg(MAX_W'(a));
  assign neg_b     = twos_neg(MAX_W'(b));
  assign neg_prod  = twos_neg(MAX_W'(prod));
  assign neg_quo   = twos_neg(MAX_W'(prod[WIDTH-1:0]));
  assign neg_rmd   = twos_neg(MAX_W'(rem));
  assign abs_a     = (signed_op && a[WIDTH-1]) ? neg_a[WIDTH-1:0] : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? neg_b[WIDTH-1:0] : b;
  assign unused_neg = ^{neg_a[MAX_W-1:WIDTH], neg_b[MAX_W-1:WIDTH], neg_prod[MAX_W-1:2*WIDTH],
                        neg_quo[MAX_W-1:WIDTH], neg_rmd[MAX_W-1:WIDTH]};

  mips_cpu_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem          (rem),
    .divisor      (opr),
    .dividend_bit (prod[WIDTH-1]),
    .rem_next     (step_rem),
    .quo_bit      (step_q)
  );

`ifndef MIPS_CPU_MULDIV_FASTMUL_EN
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opr} : '0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prod      <= '0;
      rem       <= '0;
      opr       <= '0;
      neg_res   <= 1'b0;
      rem_neg   <= 1'b0;
      div0      <= 1'b0;
      is_div    <= 1'b0;
      busy      <= 1'b0;
      valid_out <= 1'b0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            case (opcode)
              FN_MTHI: begin
                hi_reg    <= a;
                valid_out <= 1'b1;
              end
              FN_MTLO: begin
                lo_reg    <= a;
                valid_out <= 1'b1;
              end
              FN_MULT, FN_MULTU: begin
                opr     <= abs_a;
                prod    <= {{WIDTH{1'b0}}, abs_b};
                neg_res <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                is_div  <= 1'b0;
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= MUL;
              end
              FN_DIV, FN_DIVU: begin
                opr     <= abs_b;
                prod    <= {{WIDTH{1'b0}}, abs_a};
                rem     <= '0;
                neg_res <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                rem_neg <= signed_op & a[WIDTH-1];
                div0    <= (b == '0);
                is_div  <= 1'b1;
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= DIV;
              end
              default: ;
            endcase
          end
        end
        MUL: begin
`ifdef MIPS_CPU_MULDIV_FASTMUL_EN
          prod  <= (2*WIDTH)'(opr) * (2*WIDTH)'(prod[WIDTH-1:0]);
          state <= FIXUP;
`else
          prod <= {mul_sum, prod[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= FIXUP;
`endif
        end
        DIV: begin
          rem              <= step_rem;
          prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], step_q};
          cnt              <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            // Divide by zero keeps the dividend in HI (sign restored) and saturates LO.
            lo_reg <= div0 ? {WIDTH{1'b1}} : (neg_res ? neg_quo[WIDTH-1:0] : prod[WIDTH-1:0]);
            hi_reg <= rem_neg ? neg_rmd[WIDTH-1:0] : rem;
          end else begin
            {hi_reg, lo_reg} <= neg_res ? neg_prod[2*WIDTH-1:0] : prod;
          end
          valid_out <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv.sv
// tb_mips_cpu_muldiv: directed + random checks of mips_cpu_muldiv against an arithmetic model.
`default_nettype none
module tb_mips_cpu_muldiv;

  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MTLO  = 6'b010011;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
`ifdef MIPS_CPU_MULDIV_FASTMUL_EN
  localparam int LMUL = 3;
`else
  localparam int LMUL = 34;
`endif
  localparam int LDIV = 34;

  typedef struct {
    int          due;
    bit          long_op;
    bit          set_hi;
    bit          set_lo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic        valid_in = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, valid_out;
  logic [31:0] hi_reg, lo_reg;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .valid_out (valid_out),
    .hi_reg    (hi_reg),
    .lo_reg    (lo_reg)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          run = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  exp_t        q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void ref_op(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] hi, output logic [31:0] lo);
    longint      sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    hi = x;
    lo = x;
    case (op)
      OP_MULT:  begin p = 64'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; hi = p[63:32]; lo = p[31:0]; end
      OP_DIV:   if (y == 0) begin lo = '1; hi = x; end
                else begin lo = 32'(sx / sy); hi = 32'(sx % sy); end
      OP_DIVU:  if (y == 0) begin lo = '1; hi = x; end
                else begin lo = x / y; hi = x % y; end
      default: ;
    endcase
  endfunction

  function automatic int op_latency(input logic [5:0] op);
    case (op)
      OP_MTHI, OP_MTLO:  return 1;
      OP_MULT, OP_MULTU: return LMUL;
      OP_DIV, OP_DIVU:   return LDIV;
      default:           return 0;
    endcase
  endfunction

  // Compare process: model state follows the expectation queue cycle by cycle.
  bit   due_now;
  logic exp_busy;
  always @(negedge clk) begin
    if (run) begin
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      due_now  = (q.size() > 0) && (q[0].due == cyc);
      exp_busy = (q.size() > 0) && q[0].long_op && (cyc < q[0].due);
      if (due_now) begin
        if (q[0].set_hi) m_hi = q[0].hi;
        if (q[0].set_lo) m_lo = q[0].lo;
        void'(q.pop_front());
      end
      chk("valid_out", {31'd0, valid_out}, {31'd0, due_now});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("hi_reg", hi_reg, m_hi);
      chk("lo_reg", lo_reg, m_lo);
    end
  end

  // Drives one request starting now; returns the accepting cycle number.
  task automatic issue(input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb, output int c0);
    exp_t        e;
    int          lat;
    logic [31:0] rh, rl;
    opcode = op; a = aa; b = bb; valid_in = 1'b1;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    c0 = cyc;
    lat = op_latency(op);
    if (lat > 0) begin
      ref_op(op, aa, bb, rh, rl);
      e.due = c0 + lat - 1; e.long_op = (lat > 1);
      e.set_hi = (op != OP_MTLO); e.set_lo = (op != OP_MTHI);
      e.hi = rh; e.lo = rl;
      q.push_back(e);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic measure(input string name, input int c0, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid_out !== 1'b1 && n < 100);
    chk(name, 32'(cyc - c0 + 1), 32'(exp_lat));
  endtask

  task automatic op_lit(input string name, input logic [5:0] op, input logic [31:0] aa, input logic [31:0] bb,
                        input int exp_lat, input logic [31:0] ehi, input logic [31:0] elo);
    int c0;
    issue(op, aa, bb, c0);
    measure({name, " latency"}, c0, exp_lat);
    chk({name, " hi"}, hi_reg, ehi);
    chk({name, " lo"}, lo_reg, elo);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          c0;
    logic [5:0]  op;
    logic [31:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    run = 1'b1;
    @(negedge clk);
    chk("reset hi", hi_reg, 32'h0);
    chk("reset lo", lo_reg, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'h0);

    // MTHI / MTLO
    op_lit("MTHI", OP_MTHI, 32'hDEADBEEF, 32'h0, 1, 32'hDEADBEEF, 32'h0);
    op_lit("MTLO", OP_MTLO, 32'h12345678, 32'h0, 1, 32'hDEADBEEF, 32'h12345678);

    // Multiply
    op_lit("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, LMUL, 32'hFFFFFFFF, 32'hFFFFFFEB);
    op_lit("MULTU max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, LMUL, 32'hFFFFFFFE, 32'h00000001);
    op_lit("MULT -3*-5", OP_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, LMUL, 32'h0, 32'd15);

    // Divide, including boundary cases
    op_lit("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, LDIV, 32'hFFFFFFFF, 32'hFFFFFFFD);
    op_lit("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, LDIV, 32'd2, 32'd14);
    op_lit("DIVU 5/0", OP_DIVU, 32'd5, 32'd0, LDIV, 32'd5, 32'hFFFFFFFF);
    op_lit("DIV -9/0", OP_DIV, 32'hFFFFFFF7, 32'd0, LDIV, 32'hFFFFFFF7, 32'hFFFFFFFF);
    op_lit("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, LDIV, 32'h0, 32'h80000000);
    op_lit("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, LDIV, 32'd1, 32'hFFFFFFFD);

    // Unknown funct is ignored
    issue(6'b100000, 32'h11111111, 32'h2, c0);
    repeat (4) @(negedge clk);

    // Request while busy is ignored, then reset mid-operation
    issue(OP_DIV, 32'd1000, 32'd3, c0);
    wait_until(c0 + 10);
    opcode = OP_MTHI; a = 32'h55555555; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    wait_until(c0 + 20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    chk("post-reset hi", hi_reg, 32'h0);
    chk("post-reset lo", lo_reg, 32'h0);
    repeat (40) @(negedge clk);

    // Random back-to-back stream
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        2: op = OP_DIV;
        default: op = OP_DIVU;
      endcase
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'h80000000;
        2: ra = 32'hFFFFFFFF;
        3: ra = 32'h7FFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'd1;
        3: rb = $urandom_range(0, 15);
        default: rb = $urandom;
      endcase
      issue(op, ra, rb, c0);
      wait_until(c0 + op_latency(op) - 1);
    end

    repeat (5) @(negedge clk);
    chk("queue drained", 32'(q.size()), 32'd0);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
